// File: rtl/game_pkg.sv
// Shared types and constants for the 4x4 game controller.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_MOVE = 2'd1,
      ST_CHECK     = 2'd2,
      ST_GAME_OVER = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P0   = 2'b01;
   localparam logic [1:0] WIN_P1   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam logic [3:0] NO_LINE   = 4'hF;
   localparam int         NUM_CELLS = 16;
   localparam int         NUM_LINES = 10;

   // Cell i is bit i, index = row*4+col. The entry at index k is line k:
   // 0-3 rows, 4-7 columns, 8 main diagonal, 9 anti-diagonal.
   localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] LINE_MASKS = {
      16'h1248,   // 9: cells 3,6,9,12
      16'h8421,   // 8: cells 0,5,10,15
      16'h8888,   // 7: column 3
      16'h4444,   // 6: column 2
      16'h2222,   // 5: column 1
      16'h1111,   // 4: column 0
      16'hF000,   // 3: row 3
      16'h0F00,   // 2: row 2
      16'h00F0,   // 1: row 1
      16'h000F    // 0: row 0
   };

endpackage

// File: rtl/game_ctrl_win_detect.sv
// Combinational line detector: reports whether a board holds any full line
// and, if so, the lowest-numbered matching line.
module win_detect
   import game_pkg::*;
(
   input  logic [NUM_CELLS-1:0] board_i,
   output logic                 hit_o,
   output logic [3:0]           line_o
);

   // Scan from the highest line down so the lowest match is the one left standing.
   always_comb begin
      hit_o  = 1'b0;
      line_o = NO_LINE;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if ((board_i & LINE_MASKS[i]) == LINE_MASKS[i]) begin
            hit_o  = 1'b1;
            line_o = 4'(i);
         end
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Turn sequencer for a two-player 4x4 line game: move handshake, occupancy
// boards, per-turn forfeit timer and win/draw evaluation.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// IDLE         | after reset, waiting for start
// WAIT_MOVE    | current player may move; turn timer running
// CHECK        | one cycle: evaluate the mover's board for a line or a draw
// GAME_OVER    | result frozen until start
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 250000000,
   parameter int          TW             = 28
) (
   input  logic        VGA_CLK_IN,
   input  logic        RST,
   input  logic        start,
   input  logic        move_valid,
   input  logic [3:0]  move_cell,
   output logic        move_ready,
   output logic        move_ack,
   output logic        move_err,
   output logic        timeout,
   output logic [15:0] board_p0,
   output logic [15:0] board_p1,
   output logic        player,
   output logic [3:0]  block,
   output logic [1:0]  state,
   output logic [1:0]  winner,
   output logic [3:0]  win_line
);

   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t                 state_q;
   logic [NUM_CELLS-1:0]   board_p0_q, board_p1_q;
   logic                   player_q;
   logic [3:0]             block_q;
   logic [1:0]             winner_q;
   logic [3:0]             win_line_q;
   logic [TW-1:0]          timer_q;
   logic                   ack_q, err_q, timeout_q;

   logic [NUM_CELLS-1:0]   cell_mask;
   logic                   cell_free;
   logic                   move_take;
   logic                   timer_expired;
   logic [TW-1:0]          timer_d;
   logic [NUM_CELLS-1:0]   board_cur;
   logic                   board_full;
   logic                   line_hit;
   logic [3:0]             line_idx;

   // Move decode, timer next value and board selection for the line check.
   always_comb begin
      cell_mask     = NUM_CELLS'(1) << move_cell;
      cell_free     = ((board_p0_q | board_p1_q) & cell_mask) == '0;
      move_take     = (state_q == ST_WAIT_MOVE) && move_valid && cell_free;
      timer_expired = (timer_q == TIMER_LAST);
      timer_d       = timer_q + TW'(1);
      board_cur     = player_q ? board_p1_q : board_p0_q;
      board_full    = (board_p0_q | board_p1_q) == '1;
   end

   win_detect u_win_detect (
      .board_i (board_cur),
      .hit_o   (line_hit),
      .line_o  (line_idx)
   );

   // Main sequencer; pulses default low and are raised for exactly one cycle.
   always_ff @(posedge VGA_CLK_IN or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         board_p0_q <= '0;
         board_p1_q <= '0;
         player_q   <= 1'b0;
         block_q    <= 4'd0;
         winner_q   <= WIN_NONE;
         win_line_q <= NO_LINE;
         timer_q    <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
               if (start) begin
                  board_p0_q <= '0;
                  board_p1_q <= '0;
                  player_q   <= 1'b0;
                  block_q    <= 4'd0;
                  winner_q   <= WIN_NONE;
                  win_line_q <= NO_LINE;
                  timer_q    <= '0;
                  state_q    <= ST_WAIT_MOVE;
               end
            end
            ST_WAIT_MOVE: begin
               if (move_take) begin
                  // An accepted move beats a simultaneous timer expiry.
                  if (player_q) board_p1_q <= board_p1_q | cell_mask;
                  else          board_p0_q <= board_p0_q | cell_mask;
                  block_q <= move_cell;
                  ack_q   <= 1'b1;
                  state_q <= ST_CHECK;
               end else begin
                  if (move_valid) err_q <= 1'b1;
                  if (timer_expired) begin
                     player_q  <= ~player_q;
                     timer_q   <= '0;
                     timeout_q <= 1'b1;
                  end else begin
                     timer_q <= timer_d;
                  end
               end
            end
            ST_CHECK: begin
               if (line_hit) begin
                  winner_q   <= player_q ? WIN_P1 : WIN_P0;
                  win_line_q <= line_idx;
                  state_q    <= ST_GAME_OVER;
               end else if (board_full) begin
                  winner_q   <= WIN_DRAW;
                  win_line_q <= NO_LINE;
                  state_q    <= ST_GAME_OVER;
               end else begin
                  player_q <= ~player_q;
                  timer_q  <= '0;
                  state_q  <= ST_WAIT_MOVE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign move_ready = (state_q == ST_WAIT_MOVE);
   assign move_ack   = ack_q;
   assign move_err   = err_q;
   assign timeout    = timeout_q;
   assign board_p0   = board_p0_q;
   assign board_p1   = board_p1_q;
   assign player     = player_q;
   assign block      = block_q;
   assign state      = state_q;
   assign winner     = winner_q;
   assign win_line   = win_line_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 250000000, WAIT_MOVE cycles allowed per turn before forfeit (10 s at 25 MHz).
REQ-002 Parameter TW, default 28, turn-timer width; SHALL hold TIMEOUT_CYCLES-1.
REQ-003 VGA_CLK_IN  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  level-sampled start/restart request.
REQ-006 move_valid  in  1  requester presents a move.
REQ-007 move_cell  in  4  target cell, index = row*4+col, row 0 on top.
REQ-008 move_ready  out  1  controller accepts a move this cycle.
REQ-009 move_ack  out  1  one-cycle pulse, move accepted.
REQ-010 move_err  out  1  one-cycle pulse, move rejected because the cell is occupied.
REQ-011 timeout  out  1  one-cycle pulse, turn forfeited.
REQ-012 board_p0, board_p1  out  16 each  cell occupancy per player; bit i = cell i.
REQ-013 player  out  1  player whose turn it is (0/1); feeds the renderer's player input.
REQ-014 block  out  4  last accepted cell; feeds the renderer's block input.
REQ-015 state  out  2  FSM state code.
REQ-016 winner  out  2  00 none, 01 player 0, 10 player 1, 11 draw.
REQ-017 win_line  out  4  winning line index 0-9; 4'hF when none.

Function
REQ-018 FSM states: IDLE=0, WAIT_MOVE=1, CHECK=2, GAME_OVER=3.
REQ-019 IDLE or GAME_OVER with start=1: clear both boards, player=0, winner=00, win_line=F, block=0, timer=0; next state WAIT_MOVE. start SHALL be ignored in WAIT_MOVE and CHECK.
REQ-020 move_ready SHALL be 1 exactly when state=WAIT_MOVE.
REQ-021 Handshake: move is taken in cycle N when move_valid=1 and move_ready=1; move_cell is sampled in cycle N only.
REQ-022 Free cell (bit clear in both boards): set the bit in the current player's board and load block=move_cell at edge N; move_ack=1 in cycle N+1; state=CHECK in cycle N+1.
REQ-023 Occupied cell: boards unchanged; move_err=1 in cycle N+1; state stays WAIT_MOVE; timer keeps counting.
REQ-024 Timer SHALL increment every WAIT_MOVE cycle with no accepted move; when it equals TIMEOUT_CYCLES-1, toggle player, clear timer, pulse timeout next cycle, stay WAIT_MOVE.
REQ-025 Free-cell move and timer expiry in the same cycle: the move SHALL win; no timeout pulse; player not toggled by the timer.
REQ-026 CHECK lasts exactly one cycle and evaluates the current player's board against ten lines: 0-3 rows 0-3, 4-7 columns 0-3, 8 main diagonal {0,5,10,15}, 9 anti-diagonal {3,6,9,12}.
REQ-027 CHECK with a full line: winner=01 or 10 per player, win_line = lowest matching index; next GAME_OVER; player unchanged.
REQ-028 CHECK with no line and all 16 cells occupied: winner=11, win_line=F; next GAME_OVER.
REQ-029 CHECK otherwise: toggle player, clear timer; next WAIT_MOVE.
REQ-030 GAME_OVER: boards, block, winner and win_line held until start.
REQ-031 board_p0 AND board_p1 SHALL be zero at all times.

Reset
REQ-032 RST=1 SHALL immediately force: state=IDLE, boards=0, player=0, block=0, winner=00, win_line=F, timer=0, move_ready/move_ack/move_err/timeout=0.
REQ-033 Reset asserted mid-game SHALL discard the game; after release the FSM waits in IDLE for start.

Structure
REQ-034 Package game_pkg SHALL hold the state enum, winner codes, NO_LINE=4'hF, NUM_CELLS=16, and the ten 16-bit line masks.
REQ-035 Sub-module win_detect SHALL be combinational: 16-bit board in; hit and 4-bit lowest line index out.

Verification (TIMEOUT_CYCLES=16)
REQ-036 Reset, start, P0 moves 0,1,2,3 interleaved with P1 moves 4,5,6 -> move_ack each, winner=01, win_line=0, state=3.
REQ-037 P0 cell 5 accepted, then P1 requests cell 5 -> move_err pulse, board_p1=0, player=1, state=1.
REQ-038 After start, no move for 16 cycles -> timeout pulse on 17th cycle, player=1; move at exact expiry cycle -> ack, no timeout.
REQ-039 Fill the board with no line -> after 16th move winner=11, win_line=F; start -> boards=0, player=0.
REQ-040 P1 completes anti-diagonal {3,6,9,12} -> winner=10, win_line=9; RST pulse mid-game -> all outputs at reset values same cycle.
